inst_fetch_buffer: RTL and testbench
====================================

# inst_fetch_buffer

Two-entry instruction queue between the AXI instruction cache (fetch stage) and the decode stage. It absorbs cache responses that arrive while decode is stalled, and presents one instruction per cycle to the decoder together with its PC and fetch-exception flags. It drops all queued instructions on a pipeline flush (exception, ERET, or branch redirect). It feeds `instrD` to the main decoder and honours the same `stallD`.

## Interface
- No parameters. Depth is fixed at 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `inst_validF` input 1: the cache presents a fetched instruction this cycle.
- `inst_readyF` output 1: the buffer can accept it. A push occurs when `inst_validF && inst_readyF`.
- `instrF` input 32: fetched instruction word.
- `pcF` input 32: PC of `instrF`.
- `is_in_delayslotF` input 1: `instrF` is a branch/jump delay-slot instruction.
- `stallD` input 1: decode is stalled and will not consume this cycle.
- `flushD` input 1: discard all queued and incoming instructions.
- `validD` output 1: the head entry is valid.
- `instrD` output 32: head instruction; 32'h0 when `validD`=0.
- `pcD` output 32: head PC; 32'h0 when `validD`=0.
- `is_in_delayslotD` output 1: head delay-slot flag; 0 when `validD`=0.
- `adelD` output 1: head instruction had a misaligned-fetch address error; 0 when `validD`=0.

## Operation
- Storage: 2 entries {instr, pc, dslot, adel}, a 1-bit head pointer, a 1-bit tail pointer, and a 2-bit count (0..2).
- `inst_readyF` = !rst && (count != 2). It depends only on registered state, with no combinational path from `stallD`.
- pop = `validD && !stallD && !flushD`.
- push = `inst_validF && inst_readyF && !flushD`.
- On push: write the entry at tail, then tail <= ~tail.
- On pop: head <= ~head.
- count update: +1 on push only, -1 on pop only, unchanged when push and pop occur together.
- `validD` = (count != 0).
- Head outputs are driven combinationally from the registered entry at head, gated to 0 when empty. An empty buffer therefore presents 32'h0 (SLL $0,$0,0, a legal NOP) and never provokes `invalidD` in decode.
- Flush: `flushD`=1 sets count <= 0 and head <= tail <= 0. Any push offered in that cycle is dropped. Flush has priority over push and pop. The fetch stage is responsible for discarding responses still in flight from the old path.
- `rst` has priority over everything: count, head, tail, and all entry fields clear to 0.
- Entry contents are never cleared on pop. Only the `validD` gating hides them.

## Timing
- Reset values: `inst_readyF`=0 while `rst`=1, and 1 from the first cycle after it; `validD`=0, `instrD`=0, `pcD`=0, `is_in_delayslotD`=0, `adelD`=0.
- Push-to-decode latency: 1 cycle. An instruction pushed at edge N is visible on the D outputs after edge N and is consumed at edge N+1 if `stallD`=0.
- Sustained throughput: 1 instruction per cycle when `stallD`=0.
- Full (count=2): `inst_readyF`=0. A pop in that cycle makes `inst_readyF`=1 in the next cycle.
- Empty plus push: no pop that cycle, because `validD`=0.
- Pointer wrap: 1 to 0 is natural 1-bit rollover. Order is preserved across wrap.
- `stallD` held for any number of cycles: outputs stay stable and the fill stops at 2.

## Configuration
- `IFBUF_ADEL_CHECK_EN` defined:
  - On push, adel <= (`pcF[1:0]` != 2'b00).
  - When adel is set, the stored instr is forced to 32'h0, so decode sees a NOP and the exception unit raises AdEL with BadVAddr = `pcD`.
- `IFBUF_ADEL_CHECK_EN` undefined:
  - adel storage is removed and `adelD` is tied to 0.
  - `instrF` is stored unmodified.

## Test plan
- Streaming: push 0x24010001 @pc 0xbfc00000, then 0x24020002 @pc 0xbfc00004 on consecutive cycles with `stallD`=0 -> `instrD` shows each for exactly one cycle in order, and `inst_readyF` stays 1.
- Stall fill: assert `stallD` and push 3 instructions -> after 2 pushes `inst_readyF`=0 and the third is held off. Release `stallD` -> the three instructions drain in order (PCs +0, +4, +8), and `inst_readyF` returns to 1 one cycle after the first pop.
- Flush mid-queue: with count=2, assert `flushD` while `inst_validF`=1 -> next cycle `validD`=0 and `instrD`=0, and the offered instruction is not stored.
- Delay slot: push a beq at 0xbfc00010 (dslot=0), then an addiu at 0xbfc00014 (dslot=1) -> `is_in_delayslotD`=1 only while the addiu is the head.
- Misaligned fetch: with the macro defined, push 0x8c010000 @pc 0xbfc00002 -> `adelD`=1 and `instrD`=0. With the macro undefined -> `adelD`=0 and `instrD`=0x8c010000.
- Reset mid-operation: assert `rst` with count=2 during a stall -> next cycle all outputs are 0, `inst_readyF`=0 while `rst`=1, then 1 once `rst` drops.

Source files
------------

// File: rtl/inst_fetch_buffer.sv
// Two-entry instruction queue between the instruction cache and decode.
// Optional misaligned-fetch detection is enabled by defining IFBUF_ADEL_CHECK_EN.
module inst_fetch_buffer (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_validF,
   output logic        inst_readyF,
   input  logic [31:0] instrF,
   input  logic [31:0] pcF,
   input  logic        is_in_delayslotF,
   input  logic        stallD,
   input  logic        flushD,
   output logic        validD,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic        is_in_delayslotD,
   output logic        adelD
);

   localparam int unsigned DEPTH = 2;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CW    = 2;

   logic [XLEN-1:0]  instr_q [DEPTH];
   logic [XLEN-1:0]  pc_q    [DEPTH];
   logic [DEPTH-1:0] dslot_q;
   logic             head_q;
   logic             tail_q;
   logic [CW-1:0]    count_q;

   logic             push_c;
   logic             pop_c;
   logic [XLEN-1:0]  instr_w;

   assign inst_readyF = !rst && (count_q != CW'(DEPTH));
   assign validD      = (count_q != CW'(0));
   assign pop_c       = validD && !stallD && !flushD;
   assign push_c      = inst_validF && inst_readyF && !flushD;

`ifdef IFBUF_ADEL_CHECK_EN
   logic [DEPTH-1:0] adel_q;
   logic             adel_w;

   // A misaligned fetch is stored as a NOP; the exception unit reports AdEL from pcD.
   assign adel_w  = (pcF[1:0] != 2'b00);
   assign instr_w = adel_w ? '0 : instrF;
   assign adelD   = validD ? adel_q[head_q] : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         adel_q <= '0;
      end else if (push_c) begin
         adel_q[tail_q] <= adel_w;
      end
   end
`else
   assign instr_w = instrF;
   assign adelD   = 1'b0;
`endif

   // Head entry presented to decode, zeroed (a legal NOP) when empty.
   assign instrD           = validD ? instr_q[head_q] : '0;
   assign pcD              = validD ? pc_q[head_q]    : '0;
   assign is_in_delayslotD = validD ? dslot_q[head_q] : 1'b0;

   // Queue storage; entries are not cleared on pop, validD hides them.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
         dslot_q <= '0;
      end else if (push_c) begin
         instr_q[tail_q] <= instr_w;
         pc_q[tail_q]    <= pcF;
         dslot_q[tail_q] <= is_in_delayslotF;
      end
   end

   // Pointers and occupancy; flush wins over push and pop.
   always_ff @(posedge clk) begin
      if (rst || flushD) begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= '0;
      end else begin
         if (push_c) tail_q <= ~tail_q;
         if (pop_c)  head_q <= ~head_q;
         case ({push_c, pop_c})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios then random traffic
// compared against a queue-based reference model.
module tb_inst_fetch_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_validF;
   logic        inst_readyF;
   logic [31:0] instrF;
   logic [31:0] pcF;
   logic        is_in_delayslotF;
   logic        stallD;
   logic        flushD;
   logic        validD;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic        is_in_delayslotD;
   logic        adelD;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        ds;
      logic        adel;
   } ent_t;

   ent_t model_q[$];

   always #5 clk = ~clk;

   inst_fetch_buffer dut (
      .clk              (clk),
      .rst              (rst),
      .inst_validF      (inst_validF),
      .inst_readyF      (inst_readyF),
      .instrF           (instrF),
      .pcF              (pcF),
      .is_in_delayslotF (is_in_delayslotF),
      .stallD           (stallD),
      .flushD           (flushD),
      .validD           (validD),
      .instrD           (instrD),
      .pcD              (pcD),
      .is_in_delayslotD (is_in_delayslotD),
      .adelD            (adelD)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // One cycle: drive inputs after the falling edge, check, then advance the model at the rising edge.
   task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic ds, input logic st, input logic fl, input logic r);
      ent_t e;
      logic exp_rdy, pop, push;
      @(negedge clk);
      rst = r; inst_validF = v; instrF = i; pcF = p;
      is_in_delayslotF = ds; stallD = st; flushD = fl;
      #1;
      exp_rdy = !r && (model_q.size() != 2);
      chk("ready", 32'(inst_readyF), 32'(exp_rdy));
      if (model_q.size() != 0) begin
         chk("validD", 32'(validD), 32'd1);
         chk("instrD", instrD, model_q[0].instr);
         chk("pcD", pcD, model_q[0].pc);
         chk("dslotD", 32'(is_in_delayslotD), 32'(model_q[0].ds));
         chk("adelD", 32'(adelD), 32'(model_q[0].adel));
      end else begin
         chk("validD", 32'(validD), 32'd0);
         chk("instrD", instrD, 32'd0);
         chk("pcD", pcD, 32'd0);
         chk("dslotD", 32'(is_in_delayslotD), 32'd0);
         chk("adelD", 32'(adelD), 32'd0);
      end
      pop  = (model_q.size() != 0) && !st && !fl;
      push = v && exp_rdy && !fl;
`ifdef IFBUF_ADEL_CHECK_EN
      e.adel  = (p % 4) != 0;
      e.instr = e.adel ? 32'd0 : i;
`else
      e.adel  = 1'b0;
      e.instr = i;
`endif
      e.pc = p;
      e.ds = ds;
      @(posedge clk);
      if (r || fl) model_q.delete();
      else begin
         if (pop)  void'(model_q.pop_front());
         if (push) model_q.push_back(e);
      end
   endtask

   task automatic idle(input logic st);
      step(1'b0, 32'd0, 32'd0, 1'b0, st, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] rp;
      rst = 1'b1; inst_validF = 1'b0; instrF = '0; pcF = '0;
      is_in_delayslotF = 1'b0; stallD = 1'b0; flushD = 1'b0;
      repeat (2) @(posedge clk);

      // Reset held, then released.
      step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1'b0);

      // Streaming.
      step(1'b1, 32'h24010001, 32'hbfc00000, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h24020002, 32'hbfc00004, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Stall fill with three offers, then drain.
      step(1'b1, 32'h24030003, 32'hbfc00100, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h24040004, 32'hbfc00104, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h24050005, 32'hbfc00108, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h24050005, 32'hbfc00108, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h24050005, 32'hbfc00108, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h24050005, 32'hbfc00108, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Flush with a full queue and an offered instruction.
      step(1'b1, 32'h11111111, 32'hbfc00200, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h22222222, 32'hbfc00204, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h33333333, 32'hbfc00208, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(1'b0);

      // Delay slot flag follows the head entry.
      step(1'b1, 32'h10220003, 32'hbfc00010, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h24210001, 32'hbfc00014, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);

      // Misaligned fetch.
      step(1'b1, 32'h8c010000, 32'hbfc00002, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);

      // Reset in the middle of a stalled, full queue.
      step(1'b1, 32'h44444444, 32'hbfc00300, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h55555555, 32'hbfc00304, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h66666666, 32'hbfc00308, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 32'h66666666, 32'hbfc00308, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(1'b0);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         rp = $urandom;
         if (($urandom % 8) != 0) rp[1:0] = 2'b00;
         step(1'(($urandom % 4) != 0), $urandom, rp, 1'($urandom % 2),
              1'(($urandom % 3) == 0), 1'(($urandom % 16) == 0), 1'(($urandom % 64) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
